// File: rtl/spi_master_mc.sv
// spi_master_mc: multi-mode SPI master (runtime CPOL/CPHA, MSB/LSB first,
// fixed SCLK divider, multi-word bursts with chip select held).
// Optional build macro SPI_LOOPBACK_EN adds a 'loopback' input that makes
// the receive path sample the internal mosi instead of the miso pin.
module spi_master_mc #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned N          = 4,
   parameter int unsigned CLK_DIV    = 4,
   localparam int unsigned SEL_W     = $clog2(N) | 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [SEL_W-1:0]      slave_sel,
   input  logic                  cpol,
   input  logic                  cpha,
   input  logic                  lsb_first,
   input  logic                  hold,
   input  logic                  miso,
`ifdef SPI_LOOPBACK_EN
   input  logic                  loopback,
`endif
   output logic                  spi_clk,
   output logic                  mosi,
   output logic [N-1:0]          cs_n,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  done,
   output logic                  busy,
   output logic                  err
);

   localparam int unsigned CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned EDGE_W = $clog2(2 * DATA_WIDTH);
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLK_DIV - 1);
   localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_XFER  = 3'd2,
      S_END   = 3'd3,
      S_WAIT  = 3'd4
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [EDGE_W-1:0]     edge_q, edge_d;
   logic [DATA_WIDTH-1:0] tx_q, tx_d;
   logic [DATA_WIDTH-1:0] rx_q, rx_d;
   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic [N-1:0]          cs_n_q, cs_n_d;
   logic                  mosi_q, mosi_d;
   logic                  sclk_q, sclk_d;
   logic                  done_q, done_d;
   logic                  busy_q, busy_d;
   logic                  err_q, err_d;
   logic                  cpol_q, cpol_d;
   logic                  cpha_q, cpha_d;
   logic                  lsb_q, lsb_d;
`ifdef SPI_LOOPBACK_EN
   logic                  lb_q, lb_d;
`endif

   logic div_tc;
   logic sel_ok;
   logic rx_bit;
   logic load;

   // Bit that goes out first for the selected order.
   function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w, input logic lsb);
      return lsb ? w[0] : w[DATA_WIDTH-1];
   endfunction

   // Drop the bit just presented so the next one is at the output end.
   function automatic logic [DATA_WIDTH-1:0] shift_tx(input logic [DATA_WIDTH-1:0] w,
                                                      input logic lsb);
      return lsb ? {1'b0, w[DATA_WIDTH-1:1]} : {w[DATA_WIDTH-2:0], 1'b0};
   endfunction

   // Receive shift uses the same bit order as transmit.
   function automatic logic [DATA_WIDTH-1:0] shift_rx(input logic [DATA_WIDTH-1:0] w,
                                                      input logic b, input logic lsb);
      return lsb ? {b, w[DATA_WIDTH-1:1]} : {w[DATA_WIDTH-2:0], b};
   endfunction

   // One-hot active-low chip select for a valid slave index.
   function automatic logic [N-1:0] cs_decode(input logic [SEL_W-1:0] s);
      logic [N-1:0] r;
      r = '1;
      for (int unsigned i = 0; i < N; i++) begin
         if (32'(s) == i) r[i] = 1'b0;
      end
      return r;
   endfunction

   assign div_tc = (cnt_q == CNT_LAST);
   assign sel_ok = (32'(slave_sel) < N);

   // Receive source: miso pin, or internal mosi when loopback was latched.
`ifdef SPI_LOOPBACK_EN
   assign rx_bit = lb_q ? mosi_q : miso;
`else
   assign rx_bit = miso;
`endif

   // Next-state and datapath logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      edge_d  = edge_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      dout_d  = dout_q;
      cs_n_d  = cs_n_q;
      mosi_d  = mosi_q;
      sclk_d  = sclk_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      busy_d  = busy_q;
      cpol_d  = cpol_q;
      cpha_d  = cpha_q;
      lsb_d   = lsb_q;
`ifdef SPI_LOOPBACK_EN
      lb_d    = lb_q;
`endif
      load    = 1'b0;

      case (state_q)
         S_IDLE: begin
            sclk_d = cpol;
            cnt_d  = '0;
            edge_d = '0;
            if (start) begin
               if (sel_ok) begin
                  load   = 1'b1;
                  cs_n_d = cs_decode(slave_sel);
                  busy_d = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_SETUP: begin
            if (div_tc) begin
               cnt_d   = '0;
               state_d = S_XFER;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_XFER: begin
            if (div_tc) begin
               cnt_d  = '0;
               sclk_d = ~sclk_q;
               // Even edge_q is a leading edge; sample there when cpha=0.
               if (~edge_q[0] ^ cpha_q) begin
                  rx_d = shift_rx(rx_q, rx_bit, lsb_q);
               end else if (edge_q != EDGE_LAST) begin
                  mosi_d = first_bit(tx_q, lsb_q);
                  tx_d   = shift_tx(tx_q, lsb_q);
               end
               if (edge_q == EDGE_LAST) begin
                  edge_d  = '0;
                  state_d = S_END;
               end else begin
                  edge_d = edge_q + EDGE_W'(1);
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_END: begin
            if (div_tc) begin
               cnt_d  = '0;
               done_d = 1'b1;
               dout_d = rx_q;
               if (hold) begin
                  state_d = S_WAIT;
               end else begin
                  state_d = S_IDLE;
                  cs_n_d  = '1;
                  busy_d  = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_WAIT: begin
            if (start) begin
               load = 1'b1;
            end else if (!hold) begin
               state_d = S_IDLE;
               cs_n_d  = '1;
               busy_d  = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Word accept (from IDLE or WAIT): latch mode and data, preload first bit for cpha=0.
      if (load) begin
         cpol_d  = cpol;
         cpha_d  = cpha;
         lsb_d   = lsb_first;
`ifdef SPI_LOOPBACK_EN
         lb_d    = loopback;
`endif
         sclk_d  = cpol;
         cnt_d   = '0;
         edge_d  = '0;
         state_d = S_SETUP;
         if (!cpha) begin
            mosi_d = first_bit(data_in, lsb_first);
            tx_d   = shift_tx(data_in, lsb_first);
         end else begin
            tx_d = data_in;
         end
      end
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         edge_q  <= '0;
         tx_q    <= '0;
         rx_q    <= '0;
         dout_q  <= '0;
         cs_n_q  <= '1;
         mosi_q  <= 1'b0;
         sclk_q  <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
         cpol_q  <= 1'b0;
         cpha_q  <= 1'b0;
         lsb_q   <= 1'b0;
`ifdef SPI_LOOPBACK_EN
         lb_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         edge_q  <= edge_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         dout_q  <= dout_d;
         cs_n_q  <= cs_n_d;
         mosi_q  <= mosi_d;
         sclk_q  <= sclk_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
         cpol_q  <= cpol_d;
         cpha_q  <= cpha_d;
         lsb_q   <= lsb_d;
`ifdef SPI_LOOPBACK_EN
         lb_q    <= lb_d;
`endif
      end
   end

   assign spi_clk  = sclk_q;
   assign mosi     = mosi_q;
   assign cs_n     = cs_n_q;
   assign data_out = dout_q;
   assign done     = done_q;
   assign busy     = busy_q;
   assign err      = err_q;

endmodule

// File: tb/tb_spi_master_mc.sv
// Testbench for spi_master_mc: table of single-word transfers in all modes,
// plus burst, error, mid-transfer reset and (optionally) loopback sequences.
module tb_spi_master_mc;

   localparam int unsigned DW  = 8;
   localparam int unsigned NS  = 4;
   localparam int unsigned DIV = 4;
   localparam int          LAT = (2 * DW + 2) * DIV;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic [DW-1:0] data_in = '0;
   logic [2:0]    slave_sel = '0;
   logic          cpol = 1'b0;
   logic          cpha = 1'b0;
   logic          lsb_first = 1'b0;
   logic          hold = 1'b0;
   logic          miso;
`ifdef SPI_LOOPBACK_EN
   logic          loopback = 1'b0;
`endif
   logic          spi_clk;
   logic          mosi;
   logic [NS-1:0] cs_n;
   logic [DW-1:0] data_out;
   logic          done;
   logic          busy;
   logic          err;

   int n_tests = 0;
   int n_fail  = 0;

   spi_master_mc #(.DATA_WIDTH(DW), .N(NS), .CLK_DIV(DIV)) dut (
      .clk(clk), .rst(rst), .start(start), .data_in(data_in), .slave_sel(slave_sel),
      .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .hold(hold), .miso(miso),
`ifdef SPI_LOOPBACK_EN
      .loopback(loopback),
`endif
      .spi_clk(spi_clk), .mosi(mosi), .cs_n(cs_n), .data_out(data_out),
      .done(done), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   // Behavioural slave: counts SCLK edges while selected, drives miso, captures mosi.
   logic [7:0] s_word = 8'h00;
   logic       s_cpha = 1'b0;
   logic       s_lsb  = 1'b0;
   logic [7:0] s_rx   = 8'h00;
   logic       last_sclk = 1'b0;
   int         ecnt = 0;
   int         m_e, m_b, m_p;

   always @(spi_clk or cs_n) begin
      if (&cs_n) begin
         ecnt = 0;
      end else if (spi_clk !== last_sclk) begin
         ecnt++;
         if (s_cpha ? (ecnt % 2 == 0) : (ecnt % 2 == 1))
            s_rx = s_lsb ? {mosi, s_rx[7:1]} : {s_rx[6:0], mosi};
      end
      last_sclk = spi_clk;
   end

   always @* begin
      m_e = ecnt % 16;
      m_b = s_cpha ? ((m_e + 15) % 16) / 2 : m_e / 2;
      m_p = s_lsb ? m_b : 7 - m_b;
      miso = (&cs_n) ? 1'b0 : s_word[m_p[2:0]];
   end

   // Count CS releases and done pulses.
   int   rel_cnt  = 0;
   int   done_cnt = 0;
   logic prev_all = 1'b1;
   always @(negedge clk) begin
      if ((&cs_n) && !prev_all) rel_cnt++;
      prev_all = &cs_n;
      if (done === 1'b1) done_cnt++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One word transfer; optional mid-transfer start poke to prove it is ignored.
   task automatic run_word(input logic cp, input logic ch, input logic lsb,
                           input logic [2:0] sel, input logic [7:0] din, input logic [7:0] sw,
                           input logic hd, input logic poke, input logic [7:0] exp_dout,
                           input logic [3:0] exp_cs, input string tag);
      int   cyc;
      logic cs_bad;
      logic err_seen;
      @(negedge clk);
      cpol = cp;
      @(negedge clk);
      cpha = ch; lsb_first = lsb; slave_sel = sel; data_in = din; hold = hd;
      s_word = sw; s_cpha = ch; s_lsb = lsb;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, " busy_rise"}, busy, 1'b1);
      cyc = 0; cs_bad = 1'b0; err_seen = 1'b0;
      while (done !== 1'b1 && cyc < LAT + 20) begin
         if (cs_n !== exp_cs) cs_bad = 1'b1;
         if (err !== 1'b0) err_seen = 1'b1;
         if (poke && cyc == 20) begin
            start = 1'b1; data_in = ~din; slave_sel = 3'd0; cpol = ~cp; lsb_first = ~lsb;
         end else if (poke && cyc == 21) begin
            start = 1'b0; data_in = din; slave_sel = sel; cpol = cp; lsb_first = lsb;
         end
         @(negedge clk);
         cyc++;
      end
      check({tag, " latency"}, cyc, LAT);
      check({tag, " cs_n_during"}, cs_bad, 1'b0);
      check({tag, " no_err"}, err_seen | err, 1'b0);
      check({tag, " data_out"}, data_out, exp_dout);
      check({tag, " mosi_word"}, s_rx, din);
      if (hd) begin
         check({tag, " busy_hold"}, busy, 1'b1);
         check({tag, " cs_hold"}, cs_n, exp_cs);
      end else begin
         check({tag, " busy_fall"}, busy, 1'b0);
         check({tag, " cs_release"}, cs_n, 4'hF);
      end
      @(negedge clk);
      check({tag, " done_pulse"}, done, 1'b0);
      if (!hd) begin
         check({tag, " sclk_idle"}, spi_clk, cp);
         check({tag, " no_requeue"}, busy, 1'b0);
      end
   endtask

   typedef struct {
      logic       cp;
      logic       ch;
      logic       lsb;
      logic [2:0] sel;
      logic [7:0] din;
      logic [7:0] sw;
      logic       poke;
      logic [7:0] exp_dout;
      logic [3:0] exp_cs;
   } vec_t;

   vec_t vt[6];

   initial begin
      vt[0] = '{1'b0, 1'b0, 1'b0, 3'd1, 8'hA5, 8'h3C, 1'b0, 8'h3C, 4'b1101};
      vt[1] = '{1'b0, 1'b1, 1'b0, 3'd1, 8'hA5, 8'h3C, 1'b1, 8'h3C, 4'b1101};
      vt[2] = '{1'b1, 1'b0, 1'b0, 3'd1, 8'hA5, 8'h3C, 1'b0, 8'h3C, 4'b1101};
      vt[3] = '{1'b1, 1'b1, 1'b0, 3'd1, 8'hA5, 8'h3C, 1'b0, 8'h3C, 4'b1101};
      vt[4] = '{1'b0, 1'b0, 1'b1, 3'd0, 8'h01, 8'h80, 1'b0, 8'h80, 4'b1110};
      vt[5] = '{1'b1, 1'b1, 1'b1, 3'd3, 8'h5A, 8'hC7, 1'b0, 8'hC7, 4'b0111};

      // Reset state.
      repeat (3) @(negedge clk);
      check("rst spi_clk", spi_clk, 1'b0);
      check("rst mosi", mosi, 1'b0);
      check("rst cs_n", cs_n, 4'hF);
      check("rst data_out", data_out, 8'h00);
      check("rst done_busy_err", {done, busy, err}, 3'b000);
      rst = 1'b1;

      for (int i = 0; i < 6; i++) begin
         run_word(vt[i].cp, vt[i].ch, vt[i].lsb, vt[i].sel, vt[i].din, vt[i].sw, 1'b0,
                  vt[i].poke, vt[i].exp_dout, vt[i].exp_cs, $sformatf("vec%0d", i));
      end

      // Burst of three words with CS held.
      rel_cnt = 0; done_cnt = 0;
      run_word(1'b0, 1'b0, 1'b0, 3'd2, 8'h11, 8'hA1, 1'b1, 1'b0, 8'hA1, 4'b1011, "burst0");
      run_word(1'b0, 1'b0, 1'b0, 3'd2, 8'h22, 8'hB2, 1'b1, 1'b0, 8'hB2, 4'b1011, "burst1");
      check("burst no_release_mid", rel_cnt, 0);
      run_word(1'b0, 1'b0, 1'b0, 3'd2, 8'h33, 8'hC3, 1'b0, 1'b0, 8'hC3, 4'b1011, "burst2");
      check("burst releases", rel_cnt, 1);
      check("burst dones", done_cnt, 3);

      // Invalid slave index: err pulse, nothing else moves.
      for (int s = 4; s < 6; s++) begin
         @(negedge clk);
         slave_sel = 3'(s); start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         check($sformatf("err%0d pulse", s), err, 1'b1);
         check($sformatf("err%0d busy_done", s), {busy, done}, 2'b00);
         check($sformatf("err%0d cs_n", s), cs_n, 4'hF);
         @(negedge clk);
         check($sformatf("err%0d clear", s), err, 1'b0);
      end

      // Reset sampled at the 7th SCLK edge of XFER.
      @(negedge clk);
      cpol = 1'b1;
      @(negedge clk);
      cpha = 1'b1; lsb_first = 1'b0; slave_sel = 3'd2; data_in = 8'h96; hold = 1'b0;
      s_word = 8'h5A; s_cpha = 1'b1; s_lsb = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (31) @(negedge clk);
      check("rst_mid pre_sclk", spi_clk, 1'b1);
      check("rst_mid pre_cs", cs_n, 4'b1011);
      rst = 1'b0;
      @(negedge clk);
      check("rst_mid spi_clk", spi_clk, 1'b0);
      check("rst_mid mosi", mosi, 1'b0);
      check("rst_mid cs_n", cs_n, 4'hF);
      check("rst_mid data_out", data_out, 8'h00);
      check("rst_mid done_busy_err", {done, busy, err}, 3'b000);
      rst = 1'b1;
      done_cnt = 0;
      repeat (100) @(negedge clk);
      check("rst_mid no_done", done_cnt, 0);
      check("rst_mid idle_sclk", spi_clk, 1'b1);

`ifdef SPI_LOOPBACK_EN
      loopback = 1'b1;
      run_word(1'b0, 1'b0, 1'b0, 3'd0, 8'hC3, 8'h00, 1'b0, 1'b0, 8'hC3, 4'b1110, "loopback");
      loopback = 1'b0;
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
